motor_ufeed_acq: RTL and testbench
==================================

MOTOR_UFEED_ACQ -- requirements
Module: motor_ufeed_acq

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 4, meaning the SCLK half-period in clk_i cycles (legal range 2..255).
REQ-002 The block SHALL have parameter CS_SETUP, default 2, meaning clk_i cycles from CS fall to the first SCLK rise.
REQ-003 The block SHALL have parameter CS_HOLD, default 2, meaning clk_i cycles from the last SCLK fall to CS rise.
REQ-004 The block SHALL have port clk_i, input, 1 bit: the single clock.
REQ-005 The block SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The block SHALL have port acq_en_i, input, 1 bit: enables periodic acquisition.
REQ-007 The block SHALL have port sample_period_i, input, 16 bits: conversion period in clk_i cycles.
REQ-008 The block SHALL have port adc_cs_n_o, output, 1 bit: ADC chip select, active-low.
REQ-009 The block SHALL have port adc_sclk_o, output, 1 bit: ADC serial clock, idle low.
REQ-010 The block SHALL have port adc_sdo_i, input, 1 bit: ADC serial data, MSB first.
REQ-011 The block SHALL have port motor_Ufeed_en_o, output, 1 bit: single-cycle Ufeed valid strobe.
REQ-012 The block SHALL have port motor_Ufeed_o, output, 16 bits: Ufeed sample, held between strobes.
REQ-013 The block SHALL have port overrun_o, output, 1 bit: sticky flag, a period tick arrived while a frame was busy.
REQ-014 The block SHALL have port overrun_clr_i, input, 1 bit: clears overrun_o.

Function
REQ-015 The period counter SHALL run only while acq_en_i=1 and SHALL emit a tick every max(sample_period_i,1) cycles.
- The first tick comes sample_period_i cycles after acq_en_i rises.
- The reload value is sampled at each tick.
REQ-016 The FSM SHALL have the states IDLE, SETUP, SHIFT, HOLD, OUT:
- IDLE->SETUP on a tick, with CS driven low.
- SETUP->SHIFT after CS_SETUP cycles.
- SHIFT->HOLD after the 16th SCLK fall.
- HOLD->OUT after CS_HOLD cycles, with CS driven high.
- OUT->IDLE after one cycle.
REQ-017 In SHIFT, adc_sclk_o SHALL toggle every CLK_DIV cycles starting high, and adc_sdo_i SHALL be captured on each rising transition, MSB first.
REQ-018 In OUT, motor_Ufeed_en_o SHALL pulse for exactly one cycle and motor_Ufeed_o SHALL update in the same cycle.
REQ-019 Latency from tick to strobe SHALL be CS_SETUP+32*CLK_DIV+CS_HOLD+1 cycles, which is 133 at the defaults.
REQ-020 A tick arriving in any state other than IDLE SHALL be dropped and SHALL set overrun_o; the frame in progress is unaffected.
REQ-021 If overrun_clr_i and an overrun event occur in the same cycle, set SHALL win.
REQ-022 If acq_en_i falls mid-frame, the current frame SHALL complete and strobe, and no further ticks SHALL be generated.
REQ-023 adc_cs_n_o SHALL be high and adc_sclk_o SHALL be low in IDLE and OUT.

Reset
REQ-024 While rst_i=1, the outputs SHALL take these values:
- adc_cs_n_o=1, adc_sclk_o=0.
- motor_Ufeed_en_o=0, motor_Ufeed_o=0, overrun_o=0.
- FSM=IDLE, all counters 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately with no strobe; after release, acquisition restarts per REQ-015.

Configuration
REQ-026 With macro UFEED_AVG_EN defined, the block SHALL do the following:
- Accumulate 4 consecutive conversions in an 18-bit sum.
- Strobe only on every 4th conversion, with motor_Ufeed_o = sum[17:2] (truncating).
- Clear the accumulator on reset and whenever acq_en_i is 0.
REQ-027 Without UFEED_AVG_EN, every conversion SHALL strobe its raw 16-bit value and no accumulator SHALL be instantiated.

Structure
REQ-028 Package ufeed_acq_pkg SHALL hold:
- The FSM state enum.
- The ADC frame width (16).
- The averaging depth (4) and accumulator width (18).
REQ-029 SCLK generation and the 16-bit shift register SHALL be in sub-module ufeed_spi_rx, with inputs start and clk_div and outputs done, data[15:0] and sclk; the FSM and period logic stay in motor_ufeed_acq.

Verification
REQ-030 Scenario (defaults, sample_period_i=200, ADC model returns 16'hA5C3):
- Strobe every 200 cycles, with motor_Ufeed_o=16'hA5C3.
- First strobe 133 cycles after the first tick.
- 16 SCLK rises per frame.
REQ-031 Scenario (sample_period_i=100, frame needs 133 cycles):
- overrun_o=1 after the second tick.
- One strobe per 2 ticks.
- overrun_clr_i pulse coinciding with an overrun leaves overrun_o=1.
REQ-032 Scenario (acq_en_i dropped 40 cycles into SHIFT):
- The frame completes and strobes once.
- No further CS activity.
REQ-033 Scenario (rst_i asserted 50 cycles into SHIFT):
- cs_n=1 and sclk=0 immediately.
- No strobe.
- First post-reset strobe arrives sample_period_i+133 cycles after release.
REQ-034 Scenario (UFEED_AVG_EN defined, ADC returns 16'h0001, 16'h0002, 16'h0003, 16'h0006):
- A single strobe after the 4th conversion, with motor_Ufeed_o=16'h0003.
- Repeated with all four samples at 16'hFFFF: motor_Ufeed_o=16'hFFFF (no overflow).
REQ-035 Scenario (sample_period_i=0, then 1):
- Ticks every cycle in both cases.
- Back-to-back frames with continuous overrun_o=1 and no lockup.

Source files
------------

// File: rtl/ufeed_acq_pkg.sv
// ---------------------------------------------------------------------------
// ufeed_acq_pkg
// Shared types and constants for the motor Ufeed ADC acquisition block.
//   acq_state_t : frame sequencer states
//   ADC_W       : ADC frame width in bits
//   AVG_DEPTH   : conversions averaged per strobe (UFEED_AVG_EN builds)
//   ACC_W       : accumulator width for the averaging sum
// ---------------------------------------------------------------------------
package ufeed_acq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_HOLD  = 3'd3,
    ST_OUT   = 3'd4
  } acq_state_t;

  localparam int ADC_W     = 16;
  localparam int AVG_DEPTH = 4;
  localparam int ACC_W     = 18;

endpackage

// File: rtl/motor_ufeed_acq_spi_rx.sv
// ---------------------------------------------------------------------------
// ufeed_spi_rx
// SPI receive engine: generates SCLK and shifts in one ADC_W-bit frame.
// A start pulse raises SCLK on the following cycle; SCLK then toggles every
// clk_div cycles for 2*ADC_W half-periods, and sdo is sampled at each edge
// of clk where SCLK goes high (MSB first). done pulses in the last cycle of
// the final low half-period, when data holds the complete word.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   start     : one-cycle frame start
//   clk_div   : SCLK half-period in clk cycles (>= 2)
//   sdo       : serial data from the ADC
//   done      : one-cycle end-of-frame pulse
//   data      : received word
//   sclk      : serial clock, idle low
// ---------------------------------------------------------------------------
module ufeed_spi_rx
  import ufeed_acq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [7:0]       clk_div,
  input  logic             sdo,
  output logic             done,
  output logic [ADC_W-1:0] data,
  output logic             sclk
);

  localparam logic [5:0] LAST_HALF = 6'(2*ADC_W - 1);

  logic             active_q;
  logic [7:0]       div_cnt_q;
  logic [5:0]       half_cnt_q;
  logic             sclk_q;
  logic [ADC_W-1:0] shreg_q;
  logic             half_end;
  logic             shift_en;

  assign half_end = active_q && (div_cnt_q == clk_div - 8'd1);
  assign done     = half_end && (half_cnt_q == LAST_HALF);
  // A rising SCLK transition happens at start and at each low->high toggle.
  assign shift_en = start || (half_end && !done && !sclk_q);
  assign data     = shreg_q;
  assign sclk     = sclk_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_q   <= 1'b0;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      sclk_q     <= 1'b0;
    end else if (start) begin
      active_q   <= 1'b1;
      div_cnt_q  <= '0;
      half_cnt_q <= '0;
      sclk_q     <= 1'b1;
    end else if (half_end) begin
      div_cnt_q <= '0;
      if (done) begin
        active_q <= 1'b0;
        sclk_q   <= 1'b0;
      end else begin
        half_cnt_q <= half_cnt_q + 6'd1;
        sclk_q     <= ~sclk_q;
      end
    end else if (active_q) begin
      div_cnt_q <= div_cnt_q + 8'd1;
    end
  end

  // Shift register is pure datapath; its content is only consumed after a
  // full frame has overwritten every bit.
  always_ff @(posedge clk) begin
    if (shift_en) shreg_q <= {shreg_q[ADC_W-2:0], sdo};
  end

endmodule

// File: rtl/motor_ufeed_acq.sv
// ---------------------------------------------------------------------------
// motor_ufeed_acq
// Periodic acquisition of the motor feed voltage (Ufeed) from a serial ADC.
// A period counter issues ticks every max(sample_period_i,1) cycles while
// acq_en_i is high; each tick accepted in IDLE runs one CS/SCLK frame and
// strobes the result. Ticks arriving during a frame are dropped and set the
// sticky overrun flag (set wins over clear).
// Build option: define UFEED_AVG_EN to average AVG_DEPTH conversions and
// strobe once per group with the truncated mean; otherwise every conversion
// is strobed raw.
// Ports:
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   acq_en_i            : enable periodic acquisition
//   sample_period_i     : conversion period in clk_i cycles
//   adc_cs_n_o          : ADC chip select (active low)
//   adc_sclk_o          : ADC serial clock (idle low)
//   adc_sdo_i           : ADC serial data, MSB first
//   motor_Ufeed_en_o    : one-cycle sample valid strobe
//   motor_Ufeed_o       : sample value, held between strobes
//   overrun_o           : sticky overrun flag
//   overrun_clr_i       : overrun clear
// Parameters: CLK_DIV (SCLK half-period), CS_SETUP, CS_HOLD (>= 1).
// ---------------------------------------------------------------------------
module motor_ufeed_acq
  import ufeed_acq_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        acq_en_i,
  input  logic [15:0] sample_period_i,
  output logic        adc_cs_n_o,
  output logic        adc_sclk_o,
  input  logic        adc_sdo_i,
  output logic        motor_Ufeed_en_o,
  output logic [15:0] motor_Ufeed_o,
  output logic        overrun_o,
  input  logic        overrun_clr_i
);

  localparam logic [15:0] SETUP_LAST = 16'(CS_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(CS_HOLD - 1);

  acq_state_t       state_q, state_d;
  logic [15:0]      phase_cnt_q;
  logic             run_q;
  logic [15:0]      per_cnt_q;
  logic [15:0]      reload;
  logic             tick;
  logic             spi_start;
  logic             spi_done;
  logic             spi_sclk;
  logic [ADC_W-1:0] spi_data;
  logic             frame_done;
  logic             overrun_q;
  logic [15:0]      ufeed_q;

  // Period counter: loads on enable and at every tick, ticks at zero.
  assign reload = (sample_period_i == 16'd0) ? 16'd0 : sample_period_i - 16'd1;
  assign tick   = acq_en_i && run_q && (per_cnt_q == 16'd0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_q     <= 1'b0;
      per_cnt_q <= '0;
    end else if (!acq_en_i) begin
      run_q     <= 1'b0;
      per_cnt_q <= '0;
    end else if (!run_q || tick) begin
      run_q     <= 1'b1;
      per_cnt_q <= reload;
    end else begin
      per_cnt_q <= per_cnt_q - 16'd1;
    end
  end

  // Frame sequencer
  always_comb begin
    state_d    = state_q;
    spi_start  = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      ST_IDLE:  if (tick) state_d = ST_SETUP;
      ST_SETUP: if (phase_cnt_q == SETUP_LAST) begin
                  state_d   = ST_SHIFT;
                  spi_start = 1'b1;
                end
      ST_SHIFT: if (spi_done) state_d = ST_HOLD;
      ST_HOLD:  if (phase_cnt_q == HOLD_LAST) begin
                  state_d    = ST_OUT;
                  frame_done = 1'b1;
                end
      ST_OUT:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      phase_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q)
        phase_cnt_q <= '0;
      else if (state_q == ST_SETUP || state_q == ST_HOLD)
        phase_cnt_q <= phase_cnt_q + 16'd1;
    end
  end

  ufeed_spi_rx u_spi_rx (
    .clk     (clk_i),
    .rst     (rst_i),
    .start   (spi_start),
    .clk_div (8'(CLK_DIV)),
    .sdo     (adc_sdo_i),
    .done    (spi_done),
    .data    (spi_data),
    .sclk    (spi_sclk)
  );

  assign adc_cs_n_o = !(state_q == ST_SETUP || state_q == ST_SHIFT || state_q == ST_HOLD);
  assign adc_sclk_o = spi_sclk && (state_q == ST_SHIFT);

  // Overrun: a dropped tick sets the flag and takes priority over clear.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      overrun_q <= 1'b0;
    else if (tick && state_q != ST_IDLE)
      overrun_q <= 1'b1;
    else if (overrun_clr_i)
      overrun_q <= 1'b0;
  end

  assign overrun_o = overrun_q;

`ifdef UFEED_AVG_EN
  localparam logic [1:0] AVG_LAST = 2'(AVG_DEPTH - 1);

  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_sum;
  logic [1:0]       avg_cnt_q;
  logic             avg_hit_q;

  assign acc_sum = acc_q + ACC_W'(spi_data);

  // A conversion finishing while disabled is discarded with the group.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
      avg_hit_q <= 1'b0;
      ufeed_q   <= '0;
    end else if (frame_done && acq_en_i) begin
      if (avg_cnt_q == AVG_LAST) begin
        ufeed_q   <= acc_sum[ACC_W-1 -: ADC_W];
        acc_q     <= '0;
        avg_cnt_q <= '0;
        avg_hit_q <= 1'b1;
      end else begin
        acc_q     <= acc_sum;
        avg_cnt_q <= avg_cnt_q + 2'd1;
        avg_hit_q <= 1'b0;
      end
    end else begin
      avg_hit_q <= 1'b0;
      if (!acq_en_i) begin
        acc_q     <= '0;
        avg_cnt_q <= '0;
      end
    end
  end

  assign motor_Ufeed_en_o = (state_q == ST_OUT) && avg_hit_q;
`else
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      ufeed_q <= '0;
    else if (frame_done)
      ufeed_q <= spi_data;
  end

  assign motor_Ufeed_en_o = (state_q == ST_OUT);
`endif

  assign motor_Ufeed_o = ufeed_q;

endmodule

// File: tb/tb_motor_ufeed_acq.sv
// ---------------------------------------------------------------------------
// tb_motor_ufeed_acq
// Randomized bench for motor_ufeed_acq. The reference model predicts, from
// tick times and frame start times, the expected chip select, serial clock,
// strobe, sample value and overrun flag of every cycle.
// ---------------------------------------------------------------------------
module tb_motor_ufeed_acq;

  localparam int CLK_DIV  = 4;
  localparam int CS_SETUP = 2;
  localparam int CS_HOLD  = 2;
  localparam int SHIFT_N  = 32 * CLK_DIV;
  localparam int LAT      = CS_SETUP + SHIFT_N + CS_HOLD + 1;

  logic        clk;
  logic        rst_i;
  logic        acq_en_i;
  logic [15:0] sample_period_i;
  logic        adc_cs_n_o;
  logic        adc_sclk_o;
  logic        adc_sdo_i;
  logic        motor_Ufeed_en_o;
  logic [15:0] motor_Ufeed_o;
  logic        overrun_o;
  logic        overrun_clr_i;

  motor_ufeed_acq #(
    .CLK_DIV  (CLK_DIV),
    .CS_SETUP (CS_SETUP),
    .CS_HOLD  (CS_HOLD)
  ) dut (
    .clk_i            (clk),
    .rst_i            (rst_i),
    .acq_en_i         (acq_en_i),
    .sample_period_i  (sample_period_i),
    .adc_cs_n_o       (adc_cs_n_o),
    .adc_sclk_o       (adc_sclk_o),
    .adc_sdo_i        (adc_sdo_i),
    .motor_Ufeed_en_o (motor_Ufeed_en_o),
    .motor_Ufeed_o    (motor_Ufeed_o),
    .overrun_o        (overrun_o),
    .overrun_clr_i    (overrun_clr_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
    end
  endtask

  // ADC device: MSB valid after CS falls, next bit after each SCLK fall.
  logic [15:0] adc_word = 16'h0000;
  int          fall_cnt = 0;
  always @(negedge adc_cs_n_o) fall_cnt = 0;
  always @(negedge adc_sclk_o) fall_cnt = fall_cnt + 1;
  assign adc_sdo_i = (fall_cnt < 16) ? adc_word[15 - fall_cnt] : 1'b0;

  // Word source per frame
  int          word_mode = 0;
  int          seq_idx   = 0;
  logic [15:0] seq_tab [8] = '{16'h0001, 16'h0002, 16'h0003, 16'h0006,
                               16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  function automatic logic [15:0] next_word();
    logic [15:0] w;
    case (word_mode)
      0:       w = 16'hA5C3;
      1:       w = 16'($urandom);
      default: begin w = seq_tab[seq_idx % 8]; seq_idx++; end
    endcase
    return w;
  endfunction

  // Reference model state
  bit          m_run      = 0;
  int          m_next     = 0;
  int          m_fs       = -100000;
  logic [15:0] m_fw       = 16'h0;
  bit          m_ovr      = 0;
  logic [15:0] m_val      = 16'h0;
  bit          m_hit      = 0;
  int          m_sum      = 0;
  int          m_n        = 0;
  int          d, k, pm;
  bit          e_cs, e_sclk, e_en, tick, busy;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_i) begin
      m_run = 0; m_fs = -100000; m_ovr = 0; m_val = 16'h0;
      m_hit = 0; m_sum = 0; m_n = 0;
      check_val("rst_cs_n", 32'(adc_cs_n_o), 32'd1);
      check_val("rst_sclk", 32'(adc_sclk_o), 32'd0);
      check_val("rst_strobe", 32'(motor_Ufeed_en_o), 32'd0);
      check_val("rst_ufeed", 32'(motor_Ufeed_o), 32'd0);
      check_val("rst_overrun", 32'(overrun_o), 32'd0);
    end else begin
      // expected outputs of this cycle
      d      = cyc - m_fs;
      e_cs   = !(d >= 1 && d <= LAT - 1);
      k      = d - 1 - CS_SETUP;
      e_sclk = (k >= 0 && k < SHIFT_N) && (((k / CLK_DIV) % 2) == 0);
`ifdef UFEED_AVG_EN
      e_en   = (d == LAT) && m_hit;
`else
      e_en   = (d == LAT);
      if (e_en) m_val = m_fw;
`endif
      check_val("cs_n", 32'(adc_cs_n_o), 32'(e_cs));
      check_val("sclk", 32'(adc_sclk_o), 32'(e_sclk));
      check_val("strobe", 32'(motor_Ufeed_en_o), 32'(e_en));
      check_val("ufeed", 32'(motor_Ufeed_o), 32'(m_val));
      check_val("overrun", 32'(overrun_o), 32'(m_ovr));

      // advance the model with this cycle's inputs
      pm   = (sample_period_i == 16'd0) ? 1 : int'(sample_period_i);
      tick = acq_en_i && m_run && (cyc == m_next);
      busy = (d >= 1 && d <= LAT);
`ifdef UFEED_AVG_EN
      if (d == LAT - 1 && acq_en_i) begin
        m_sum = m_sum + int'(m_fw);
        m_n++;
        if (m_n == 4) begin
          m_hit = 1; m_val = 16'(m_sum >> 2); m_sum = 0; m_n = 0;
        end else m_hit = 0;
      end else m_hit = 0;
      if (!acq_en_i) begin m_sum = 0; m_n = 0; end
`endif
      if (tick) begin
        m_next = cyc + pm;
        if (!busy) begin
          m_fs = cyc; m_fw = next_word(); adc_word = m_fw;
        end
      end
      if (tick && busy) m_ovr = 1;
      else if (overrun_clr_i) m_ovr = 0;
      if (!acq_en_i) m_run = 0;
      else if (!m_run) begin m_run = 1; m_next = cyc + pm; end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Wait until the current frame is `off` cycles past its tick.
  task automatic wait_frame_offset(input int off, input string tag);
    bit hit = 0;
    for (int i = 0; i < 2000; i++) begin
      step(1);
      if (cyc - m_fs == off) begin hit = 1; break; end
    end
    check_val(tag, 32'(hit), 32'd1);
  endtask

  initial begin
    rst_i = 1'b0; acq_en_i = 1'b0; sample_period_i = 16'd200; overrun_clr_i = 1'b0;
    #2 rst_i = 1'b1;
    step(3);
    rst_i = 1'b0;
    step(2);

    // steady acquisition, fixed ADC word
    word_mode = 0; sample_period_i = 16'd200; acq_en_i = 1'b1;
    step(700);

    // period shorter than a frame, random clears
    word_mode = 1; sample_period_i = 16'd100;
    for (int i = 0; i < 600; i++) begin
      overrun_clr_i = ($urandom_range(0, 5) == 0);
      step(1);
    end
    // clear exactly on every tick (some coincide with overruns)
    for (int i = 0; i < 400; i++) begin
      overrun_clr_i = (cyc == m_next);
      step(1);
    end
    overrun_clr_i = 1'b1; step(1); overrun_clr_i = 1'b0;

    // enable dropped mid-shift
    acq_en_i = 1'b0; step(150);
    sample_period_i = 16'd150; acq_en_i = 1'b1;
    wait_frame_offset(CS_SETUP + 1 + 40, "wait_shift_en");
    acq_en_i = 1'b0;
    step(400);

    // reset mid-shift
    sample_period_i = 16'($urandom_range(140, 300)); acq_en_i = 1'b1;
    wait_frame_offset(CS_SETUP + 1 + 50, "wait_shift_rst");
    rst_i = 1'b1; step(3); rst_i = 1'b0;
    step(int'(sample_period_i) + LAT + 20);

    // degenerate periods
    for (int p = 0; p < 2; p++) begin
      sample_period_i = 16'(p);
      for (int i = 0; i < 400; i++) begin
        overrun_clr_i = ($urandom_range(0, 3) == 0);
        step(1);
      end
    end
    overrun_clr_i = 1'b0;

    // averaging sequence (raw values in the default build)
    acq_en_i = 1'b0; step(140);
    word_mode = 2; seq_idx = 0; sample_period_i = 16'd140; acq_en_i = 1'b1;
    step(140 * 8 + LAT + 10);

    // random traffic
    word_mode = 1;
    for (int i = 0; i < 2500; i++) begin
      if (i % 200 == 0) sample_period_i = 16'($urandom_range(1, 300));
      if ($urandom_range(0, 99) == 0) acq_en_i = ~acq_en_i;
      overrun_clr_i = ($urandom_range(0, 7) == 0);
      step(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
